// File: rtl/sixteen_to_one_mux_pkg.sv
// Shared sizing constants for the 16:1 selector tree.
package sixteen_to_one_mux_pkg;
   localparam int NUM_LANES = 16;
   localparam int SEL_W     = 4;
endpackage

// File: rtl/sixteen_to_one_mux_mux4_to_1.sv
// W-bit 4:1 selector; leaf of the 16:1 tree.
module mux4_to_1 #(
   parameter int W = 1
) (
   input  logic [W-1:0] d0,
   input  logic [W-1:0] d1,
   input  logic [W-1:0] d2,
   input  logic [W-1:0] d3,
   input  logic [1:0]   s,
   output logic [W-1:0] y
);
   assign y = s[1] ? (s[0] ? d3 : d2) : (s[0] ? d1 : d0);
endmodule

// File: rtl/sixteen_to_one_mux.sv
// 16:1 lane selector: two-level 4:1 tree, combinational result plus a registered copy.
module sixteen_to_one_mux
   import sixteen_to_one_mux_pkg::*;
#(
   parameter int W = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_LANES*W-1:0] a,
   input  logic [SEL_W-1:0]     sel,
   input  logic                 en,
   output logic [W-1:0]         result,
   output logic [W-1:0]         result_q,
   output logic                 result_valid
);
   localparam int NUM_GRP = NUM_LANES / 4;

   logic [NUM_LANES-1:0][W-1:0] lane;
   logic [NUM_GRP-1:0][W-1:0]   grp_y;

   assign lane = a;

   // First level: sel[1:0] picks within each group of four consecutive lanes.
   for (genvar g = 0; g < NUM_GRP; g++) begin : g_l1
      mux4_to_1 #(.W(W)) u_mux (
         .d0 (lane[4*g+0]),
         .d1 (lane[4*g+1]),
         .d2 (lane[4*g+2]),
         .d3 (lane[4*g+3]),
         .s  (sel[1:0]),
         .y  (grp_y[g])
      );
   end

   mux4_to_1 #(.W(W)) u_l2 (
      .d0 (grp_y[0]),
      .d1 (grp_y[1]),
      .d2 (grp_y[2]),
      .d3 (grp_y[3]),
      .s  (sel[3:2]),
      .y  (result)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q     <= '0;
         result_valid <= 1'b0;
      end else if (en) begin
         result_q     <= result;
         result_valid <= 1'b1;
      end else begin
         result_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_sixteen_to_one_mux.sv
// Randomized and directed checks of sixteen_to_one_mux (W=1 and W=8) against a lane-index model.
module tb_sixteen_to_one_mux;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         en = 1'b0;
   logic [15:0]  a1 = '0;
   logic [3:0]   sel1 = '0;
   logic [127:0] a8 = '0;
   logic [3:0]   sel8 = '0;
   logic         r1, q1, v1;
   logic [7:0]   r8, q8;
   logic         v8;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] exp_q1, exp_q8;
   logic       exp_v1, exp_v8;

   always #5 clk = ~clk;

   sixteen_to_one_mux #(.W(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .a(a1), .sel(sel1), .en(en),
      .result(r1), .result_q(q1), .result_valid(v1)
   );
   sixteen_to_one_mux #(.W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .a(a8), .sel(sel8), .en(en),
      .result(r8), .result_q(q8), .result_valid(v8)
   );

   // Reference: lane s of a packed vector of w-bit lanes.
   function automatic logic [7:0] pick(input logic [127:0] av, input int w, input int s);
      logic [127:0] sh;
      sh = av >> (s * w);
      return (w == 8) ? sh[7:0] : {7'b0, sh[0]};
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Registered-path model: capture the selected lane when enabled.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q1 <= '0; exp_v1 <= 1'b0;
         exp_q8 <= '0; exp_v8 <= 1'b0;
      end else begin
         exp_v1 <= en;
         exp_v8 <= en;
         if (en) begin
            exp_q1 <= pick({112'b0, a1}, 1, int'(sel1));
            exp_q8 <= pick(a8, 8, int'(sel8));
         end
      end
   end

   always @(negedge clk) begin
      check("comb1", {7'b0, r1}, pick({112'b0, a1}, 1, int'(sel1)));
      check("comb8", r8, pick(a8, 8, int'(sel8)));
      check("q1", {7'b0, q1}, exp_q1);
      check("v1", {7'b0, v1}, {7'b0, exp_v1});
      check("q8", q8, exp_q8);
      check("v8", {7'b0, v8}, {7'b0, exp_v8});
   end

   initial begin
      logic [15:0] exp_bits;
      exp_bits = 16'b1010_0000_0110_0111;

      // Reset state
      #1;
      check("rst_q1", {7'b0, q1}, 8'h0);
      check("rst_v1", {7'b0, v1}, 8'h0);
      check("rst_q8", q8, 8'h0);

      // Exhaustive W=1 sweep with hand-computed expectations
      a1 = 16'ha067;
      for (int s = 0; s < 16; s++) begin
         sel1 = 4'(s);
         #5;
         check($sformatf("sweep_sel%0d", s), {7'b0, r1}, {7'b0, exp_bits[s]});
      end

      // Walking one
      for (int k = 0; k < 16; k++) begin
         a1 = 16'(1) << k;
         for (int s = 0; s < 16; s++) begin
            sel1 = 4'(s);
            #5;
            check("walk1", {7'b0, r1}, {7'b0, (s == k)});
         end
      end

      // Registered path after reset release
      @(negedge clk); #1;
      rst_n = 1'b1;
      a1 = 16'ha067; sel1 = 4'd5; en = 1'b1;
      for (int i = 0; i < 16; i++) a8[i*8 +: 8] = 8'(i);
      sel8 = 4'd12;
      #1;
      check("w8_comb_sel12", r8, 8'h0C);
      @(posedge clk); #1;
      en = 1'b0;
      check("cap_q1", {7'b0, q1}, 8'h1);
      check("cap_v1", {7'b0, v1}, 8'h1);
      check("cap_q8", q8, 8'h0C);
      @(posedge clk); #1;
      check("hold_q1", {7'b0, q1}, 8'h1);
      check("hold_v1", {7'b0, v1}, 8'h0);

      // Async reset between edges
      en = 1'b1;
      @(posedge clk); #1;
      check("pre_rst_v1", {7'b0, v1}, 8'h1);
      #2 rst_n = 1'b0;
      #1;
      check("async_q1", {7'b0, q1}, 8'h0);
      check("async_v1", {7'b0, v1}, 8'h0);
      check("async_comb", {7'b0, r1}, 8'h1);
      @(negedge clk); #1;
      rst_n = 1'b1;

      // Select change right after an enabled edge
      a1 = 16'h0008; sel1 = 4'd3; en = 1'b1;
      @(posedge clk); #1;
      sel1 = 4'd4;
      check("same_edge_l3", {7'b0, q1}, 8'h1);
      @(posedge clk); #1;
      check("same_edge_l4", {7'b0, q1}, 8'h0);

      // Randomized traffic, including occasional reset pulses
      for (int c = 0; c < 400; c++) begin
         @(negedge clk); #1;
         a1   = 16'($urandom);
         sel1 = 4'($urandom_range(0, 15));
         for (int i = 0; i < 4; i++) a8[i*32 +: 32] = $urandom;
         sel8 = 4'($urandom_range(0, 15));
         en   = 1'($urandom_range(0, 1));
         rst_n = ($urandom_range(0, 19) != 0);
      end
      @(negedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
